// File: rtl/nmr_echo_acquirer.sv
// Receive-side echo acquirer: samples the ADC on ADC_CLK rising edges inside acquisition
// windows, tags start/end of echo and streams the words out through a FWFT FIFO.
module nmr_echo_acquirer #(
    parameter int ADC_WIDTH     = 16,
    parameter int DATABUS_WIDTH = 32,
    parameter int FIFO_AW       = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     FSMSTAT,
    input  logic                     ACQ_WND,
    input  logic                     ADC_CLK,
    input  logic [ADC_WIDTH-1:0]     ADC_DATA,
    input  logic [DATABUS_WIDTH-1:0] SAMPLES_PER_ECHO,
    input  logic [DATABUS_WIDTH-1:0] ECHO_PER_SCAN,
    output logic [ADC_WIDTH+1:0]     DOUT,
    output logic                     DOUT_VALID,
    input  logic                     DOUT_READY,
    output logic                     BUSY,
    output logic [DATABUS_WIDTH-1:0] ECHO_IDX,
    output logic                     OVERFLOW,
    output logic                     SHORT_SCAN,
    output logic                     SCAN_DONE
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int WW    = ADC_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;
    state_t state_q, state_d;

    logic                     adcClk_q, acqWnd_q, fsmStat_q;
    logic [DATABUS_WIDTH-1:0] spe_q, eps_q, echoIdx_q, sampleCnt_q;
    logic                     stageValid_q, stageSoe_q;
    logic [ADC_WIDTH-1:0]     stageData_q;
    logic                     overflow_q, shortScan_q;

    logic [WW-1:0]            mem [DEPTH];
    logic [FIFO_AW-1:0]       wrPtr_q, rdPtr_q, rdPtr_d;
    logic [FIFO_AW:0]         count_q, count_d;
    logic [WW-1:0]            dout_q, head_d;
    logic                     doutValid_q;

    logic sampleEdge, windowClose, fsmRise, fsmFall;
    logic active, closeEv, fallEv, lastEcho, takeSample, limitHit;
    logic flush, push, pop, full, wrEn, scanDone;
    logic [WW-1:0] pushWord;

    assign sampleEdge  = ADC_CLK & ~adcClk_q & ACQ_WND;
    assign windowClose = ~ACQ_WND & acqWnd_q;
    assign fsmRise     = FSMSTAT & ~fsmStat_q;
    assign fsmFall     = ~FSMSTAT & fsmStat_q;

    assign active     = (state_q == ARMED) || (state_q == CAPTURE);
    assign closeEv    = (state_q == CAPTURE) && windowClose;
    assign fallEv     = active && fsmFall;
    assign lastEcho   = (echoIdx_q + DATABUS_WIDTH'(1)) == eps_q;
    assign takeSample = active && sampleEdge && !fallEv && (sampleCnt_q < spe_q);
    assign limitHit   = sampleCnt_q == spe_q;

    // The staged word leaves with EOE set once the limit is hit, the window closes or the sequence aborts.
    assign flush    = active && stageValid_q && (limitHit || closeEv || fallEv);
    assign push     = flush || (takeSample && stageValid_q);
    assign pushWord = {stageSoe_q, flush, stageData_q};

    assign full    = count_q == (FIFO_AW+1)'(DEPTH);
    assign pop     = doutValid_q & DOUT_READY;
    assign wrEn    = push && (!full || pop);
    assign rdPtr_d = rdPtr_q + FIFO_AW'(pop);
    assign count_d = count_q + (FIFO_AW+1)'(wrEn) - (FIFO_AW+1)'(pop);
    assign head_d  = (count_q == (FIFO_AW+1)'(pop)) ? pushWord : mem[rdPtr_d];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fsmRise) state_d = ARMED;
            end
            ARMED: begin
                if (fallEv)       state_d = DRAIN;
                else if (ACQ_WND) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (closeEv)     state_d = (lastEcho || fallEv) ? DRAIN : ARMED;
                else if (fallEv) state_d = DRAIN;
            end
            DRAIN: begin
                if (scanDone) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        BUSY     = state_q != IDLE;
        scanDone = (state_q == DRAIN) && (count_q == '0) && !push;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            adcClk_q     <= 1'b0;
            acqWnd_q     <= 1'b0;
            fsmStat_q    <= 1'b0;
            spe_q        <= '0;
            eps_q        <= '0;
            echoIdx_q    <= '0;
            sampleCnt_q  <= '0;
            stageValid_q <= 1'b0;
            stageSoe_q   <= 1'b0;
            stageData_q  <= '0;
            overflow_q   <= 1'b0;
            shortScan_q  <= 1'b0;
        end else begin
            adcClk_q  <= ADC_CLK;
            acqWnd_q  <= ACQ_WND;
            fsmStat_q <= FSMSTAT;
            if (state_q == IDLE && fsmRise) begin
                spe_q        <= SAMPLES_PER_ECHO;
                eps_q        <= (ECHO_PER_SCAN == '0) ? DATABUS_WIDTH'(1) : ECHO_PER_SCAN;
                echoIdx_q    <= '0;
                sampleCnt_q  <= '0;
                stageValid_q <= 1'b0;
                overflow_q   <= 1'b0;
                shortScan_q  <= 1'b0;
            end
            if (takeSample) begin
                stageValid_q <= 1'b1;
                stageSoe_q   <= sampleCnt_q == '0;
                stageData_q  <= ADC_DATA;
                sampleCnt_q  <= sampleCnt_q + DATABUS_WIDTH'(1);
            end else if (flush) begin
                stageValid_q <= 1'b0;
            end
            if (closeEv) begin
                echoIdx_q   <= echoIdx_q + DATABUS_WIDTH'(1);
                sampleCnt_q <= '0;
            end
            // An abort coinciding with the final window close is a complete scan, not a short one.
            if (fallEv && !(closeEv && lastEcho)) shortScan_q <= 1'b1;
            if (push && full && !pop)             overflow_q  <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (wrEn) mem[wrPtr_q] <= pushWord;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            doutValid_q <= 1'b0;
        end else begin
            if (wrEn) wrPtr_q <= wrPtr_q + FIFO_AW'(1);
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            doutValid_q <= count_d != '0;
            if (count_d != '0) dout_q <= head_d;
        end
    end

    assign DOUT       = dout_q;
    assign DOUT_VALID = doutValid_q;
    assign ECHO_IDX   = echoIdx_q;
    assign OVERFLOW   = overflow_q;
    assign SHORT_SCAN = shortScan_q;
    assign SCAN_DONE  = scanDone;
endmodule

// File: doc/nmr_echo_acquirer.md
# nmr_echo_acquirer

Receive-side counterpart of the NMR pulse sequencer: consumes its `ACQ_WND`, `ADC_CLK` and `FSMSTAT` outputs, samples the ADC bus once per `ADC_CLK` rising edge inside each acquisition window, and tags each sample with start and end of echo markers. Tagged samples are buffered in an internal FIFO with a valid/ready stream towards the data-capture fabric. The block counts echoes per scan, reports overflow and short scans, and pulses a done strobe when a scan has fully drained.

## Interface
- `ADC_WIDTH`, 16, ADC sample width.
- `DATABUS_WIDTH`, 32, width of the count parameters.
- `FIFO_AW`, 4, FIFO address width; depth is 2^FIFO_AW.

- `CLK`  in  1  system clock, the same clock as the pulse sequencer.
- `RESET`  in  1  synchronous, active-high reset.
- `FSMSTAT`  in  1  sequence-active flag from the pulse sequencer.
- `ACQ_WND`  in  1  acquisition window from the pulse sequencer.
- `ADC_CLK`  in  1  ADC clock from the pulse sequencer (CLK/4, synchronous to `CLK`).
- `ADC_DATA`  in  ADC_WIDTH  ADC sample, stable around `ADC_CLK` rising.
- `SAMPLES_PER_ECHO`  in  DATABUS_WIDTH  maximum samples captured per window.
- `ECHO_PER_SCAN`  in  DATABUS_WIDTH  windows per scan; 0 is treated as 1.
- `DOUT`  out  ADC_WIDTH+2  {SOE, EOE, sample}.
- `DOUT_VALID`  out  1  FIFO head valid.
- `DOUT_READY`  in  1  consumer accepts the head.
- `BUSY`  out  1  high in any state except IDLE.
- `ECHO_IDX`  out  DATABUS_WIDTH  number of completed windows in the current scan.
- `OVERFLOW`  out  1  sticky: a sample was dropped because the FIFO was full.
- `SHORT_SCAN`  out  1  sticky: `FSMSTAT` fell before `ECHO_PER_SCAN` windows completed.
- `SCAN_DONE`  out  1  one-cycle done strobe.

## Operation
- Edge detection uses registered `ADC_CLK_d`, `ACQ_WND_d` and `FSMSTAT_d`.
  - Sample edge: `ADC_CLK & ~ADC_CLK_d & ACQ_WND`.
  - Window close: `~ACQ_WND & ACQ_WND_d`.
- States: IDLE, ARMED, CAPTURE, DRAIN.
- IDLE:
  - On `FSMSTAT` rising, latch the parameters and go to ARMED.
  - On the same transition, clear `ECHO_IDX`, `OVERFLOW`, `SHORT_SCAN` and the sample counter.
- ARMED:
  - `ACQ_WND`=1 moves to CAPTURE.
  - A sample edge in the same cycle is already captured.
- CAPTURE, on each sample edge while sample count < `SAMPLES_PER_ECHO`:
  - `ADC_DATA` is loaded into a staging register.
  - Any previously staged sample is pushed to the FIFO with EOE=0.
  - SOE=1 only on the first sample of the window.
  - The sample count increments.
  - Sample edges after the limit is reached are ignored.
- Flush: the staged sample is pushed with EOE=1 and the stage is emptied. This happens on whichever comes first:
  - the cycle after the limit-th sample is staged, or
  - the window-close cycle.
- Window close:
  - `ECHO_IDX` increments and the sample count clears.
  - If `ECHO_IDX`+1 == effective `ECHO_PER_SCAN`, go to DRAIN; otherwise go to ARMED.
- A window with zero samples (`SAMPLES_PER_ECHO`=0 or no edges) pushes nothing but still counts as an echo.
- `FSMSTAT` falling in ARMED or CAPTURE: flush the stage (EOE=1), set `SHORT_SCAN`, go to DRAIN.
- DRAIN: when the FIFO is empty and no push is pending, assert `SCAN_DONE` for one cycle and go to IDLE.
- FIFO full on a push: the word is dropped and `OVERFLOW` is set. The staged/flush sequencing is unaffected.
- `FSMSTAT` rising while not in IDLE is ignored.

## Timing
- Reset values:
  - state IDLE, FIFO empty, stage empty;
  - `DOUT`=0, `DOUT_VALID`=0;
  - `BUSY`=0, `ECHO_IDX`=0, `OVERFLOW`=0, `SHORT_SCAN`=0, `SCAN_DONE`=0.
- Reset mid-scan discards all FIFO contents with no flush.
- Sample capture: `ADC_DATA` is registered in the sample-edge cycle E.
- FIFO write timing:
  - a normal push is written at the next sample edge (E+4);
  - a limit flush is written at E+1;
  - a close flush is written in the close cycle.
- At most one FIFO write per cycle. Since edges are ≥4 cycles apart, a flush and a push never collide.
- `DOUT_VALID` rises the cycle after a write into an empty FIFO.
- Pop happens on `DOUT_VALID & DOUT_READY`. `DOUT` and `DOUT_VALID` are registered, with first-word fall-through behaviour.
- Simultaneous write and read when the FIFO is full: the write succeeds and no overflow is flagged.
- `ECHO_IDX` updates the cycle after window close.
- `SCAN_DONE` fires no earlier than the cycle after the last pop.

## Test plan
- SAMPLES_PER_ECHO=4, ECHO_PER_SCAN=2, `DOUT_READY`=1, two 24-cycle windows with ADC_CLK period 4 and ADC_DATA=edge index -> 8 words. Flags per window: SOE on words 1 and 5, EOE on words 4 and 8. `ECHO_IDX` ends at 2, one `SCAN_DONE`, `OVERFLOW`=0.
- SAMPLES_PER_ECHO=10, a 12-cycle window (3 edges) -> 3 words, the last with EOE=1, emitted in the close cycle.
- SAMPLES_PER_ECHO=0, ECHO_PER_SCAN=3 -> no output words, `ECHO_IDX`=3, `SCAN_DONE` pulses.
- FIFO_AW=2, `DOUT_READY`=0, 6 samples -> 4 words held and `OVERFLOW`=1. Raising `DOUT_READY` drains 4 words, then `SCAN_DONE`.
- `FSMSTAT` dropped during window 1 of ECHO_PER_SCAN=3 -> staged word emitted with EOE=1, `SHORT_SCAN`=1, `SCAN_DONE` pulses.
- `RESET` asserted mid-CAPTURE with 3 words buffered -> next cycle `DOUT_VALID`=0, `BUSY`=0, `ECHO_IDX`=0.
